// File: rtl/ws_array_sequencer.sv
// Tile sequencer for a weight-stationary fp16 systolic array: loads weights, streams
// ifmap vectors and paces ofmap writes. All outputs are registered from next-state decode.
module ws_array_sequencer #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 12,
    parameter int AW_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_keep_weights,
    input  logic [CNT_W-1:0] i_num_vec,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stat_bit,
    output logic             o_op2_sel,
    output logic             o_out_sel,
    output logic             o_wgt_rd_en,
    output logic [AW_W-1:0]  o_wgt_rd_addr,
    output logic             o_ifm_rd_en,
    output logic [CNT_W-1:0] o_ifm_rd_addr,
    output logic             o_ofm_wr_en,
    output logic [CNT_W-1:0] o_ofm_wr_addr
);

    localparam int OUT_LAT = RD_LAT + ROWS;
    localparam logic [CNT_W:0] ROWS_LAST = (CNT_W+1)'(ROWS - 1);
    localparam logic [CNT_W:0] LAT_LAST  = (CNT_W+1)'(RD_LAT - 1);

    // Column count has no effect on sequencing; the array width only matters externally.
    if (COLS < 1) begin : g_colsUnused
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LATCH_W,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W:0]     r_cnt;
    logic [CNT_W:0]     w_nextCnt;
    logic [CNT_W-1:0]   r_numVec;
    logic               r_weightsValid;
    logic               w_startTaken;
    logic [OUT_LAT-2:0] r_pipe;
    logic [CNT_W:0]     r_wrCnt;
    logic [CNT_W:0]     w_wrCntNext;

    assign w_wrCntNext = r_wrCnt + {{CNT_W{1'b0}}, o_ofm_wr_en};

    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt + 1'b1;
        w_startTaken = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nextCnt = '0;
                if (i_start) begin
                    w_startTaken = 1'b1;
                    if (i_keep_weights && r_weightsValid)
                        w_nextState = (i_num_vec == '0) ? S_DONE : S_COMPUTE;
                    else
                        w_nextState = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (r_cnt == ROWS_LAST) begin
                    w_nextState = S_LATCH_W;
                    w_nextCnt   = '0;
                end
            end
            S_LATCH_W: begin
                if (r_cnt == LAT_LAST) begin
                    w_nextState = (r_numVec == '0) ? S_DONE : S_COMPUTE;
                    w_nextCnt   = '0;
                end
            end
            S_COMPUTE: begin
                if ((r_cnt + 1'b1) == {1'b0, r_numVec}) begin
                    w_nextState = S_DRAIN;
                    w_nextCnt   = '0;
                end
            end
            S_DRAIN: begin
                w_nextCnt = '0;
                // Count includes the write happening this cycle so DONE follows the last write.
                if (w_wrCntNext == {1'b0, r_numVec})
                    w_nextState = S_DONE;
            end
            S_DONE: begin
                w_nextCnt   = '0;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextCnt   = '0;
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_numVec       <= '0;
            r_weightsValid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_startTaken)
                r_numVec <= i_num_vec;
            if (r_state == S_IDLE && w_nextState == S_LOAD_W)
                r_weightsValid <= 1'b0;
            else if (r_state == S_LATCH_W && w_nextState != S_LATCH_W)
                r_weightsValid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_stat_bit    <= 1'b0;
            o_op2_sel     <= 1'b0;
            o_out_sel     <= 1'b0;
            o_wgt_rd_en   <= 1'b0;
            o_wgt_rd_addr <= '0;
            o_ifm_rd_en   <= 1'b0;
            o_ifm_rd_addr <= '0;
        end else begin
            o_busy        <= (w_nextState != S_IDLE);
            o_done        <= (w_nextState == S_DONE);
            o_stat_bit    <= (w_nextState != S_IDLE);
            o_op2_sel     <= (w_nextState == S_LATCH_W) && (w_nextCnt == LAT_LAST);
            o_out_sel     <= (w_nextState == S_COMPUTE) || (w_nextState == S_DRAIN);
            o_wgt_rd_en   <= (w_nextState == S_LOAD_W);
            o_wgt_rd_addr <= (w_nextState == S_LOAD_W) ?
                             (AW_W'(ROWS - 1) - w_nextCnt[AW_W-1:0]) : '0;
            o_ifm_rd_en   <= (w_nextState == S_COMPUTE);
            o_ifm_rd_addr <= (w_nextState == S_COMPUTE) ? w_nextCnt[CNT_W-1:0] : '0;
        end
    end

    // Write pacing is a pure delay of the ifmap read strobe, independent of FSM state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe        <= '0;
            r_wrCnt       <= '0;
            o_ofm_wr_en   <= 1'b0;
            o_ofm_wr_addr <= '0;
        end else begin
            r_pipe[0] <= o_ifm_rd_en;
            for (int i = 1; i < OUT_LAT - 1; i++)
                r_pipe[i] <= r_pipe[i-1];
            o_ofm_wr_en   <= r_pipe[OUT_LAT-2];
            o_ofm_wr_addr <= r_pipe[OUT_LAT-2] ? w_wrCntNext[CNT_W-1:0] : '0;
            r_wrCnt       <= w_startTaken ? '0 : w_wrCntNext;
        end
    end

endmodule

// File: tb/tb_ws_array_sequencer.sv
// Directed bench for ws_array_sequencer: runs whole tiles and compares event cycles
// and address sequences against hand-derived timings for ROWS=8, RD_LAT=1.
module tb_ws_array_sequencer;

    localparam int ROWS   = 8;
    localparam int RD_LAT = 1;
    localparam int CNT_W  = 12;
    localparam int AW_W   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             keepWeights;
    logic [CNT_W-1:0] numVec;
    logic             busy, done, statBit, op2Sel, outSel;
    logic             wgtRdEn, ifmRdEn, ofmWrEn;
    logic [AW_W-1:0]  wgtRdAddr;
    logic [CNT_W-1:0] ifmRdAddr, ofmWrAddr;

    int checks = 0;
    int passes = 0;

    int wgtCnt, wgtFirst, op2Cnt, op2Cyc, ifmCnt, ifmFirst;
    int ofmCnt, ofmFirst, doneCnt, doneCyc, busyCnt, protoErr;

    always #5 clk = ~clk;

    ws_array_sequencer #(
        .ROWS(ROWS), .COLS(8), .RD_LAT(RD_LAT), .CNT_W(CNT_W), .AW_W(AW_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_keep_weights(keepWeights),
        .i_num_vec(numVec),
        .o_busy(busy),
        .o_done(done),
        .o_stat_bit(statBit),
        .o_op2_sel(op2Sel),
        .o_out_sel(outSel),
        .o_wgt_rd_en(wgtRdEn),
        .o_wgt_rd_addr(wgtRdAddr),
        .o_ifm_rd_en(ifmRdEn),
        .o_ifm_rd_addr(ifmRdAddr),
        .o_ofm_wr_en(ofmWrEn),
        .o_ofm_wr_addr(ofmWrAddr)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected)
            passes++;
        else
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    // Issues one start in cycle 0 and records every output event until done+4 (or a budget).
    task automatic applyStimulus(input logic keep, input int nv, input bit noise);
        wgtCnt = 0; wgtFirst = -1; op2Cnt = 0; op2Cyc = -1; ifmCnt = 0; ifmFirst = -1;
        ofmCnt = 0; ofmFirst = -1; doneCnt = 0; doneCyc = -1; busyCnt = 0; protoErr = 0;
        @(posedge clk); #1;
        start = 1'b1; keepWeights = keep; numVec = CNT_W'(nv);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (wgtRdEn) begin
                if (wgtFirst < 0) wgtFirst = cyc;
                if (wgtRdAddr != AW_W'(ROWS - 1 - wgtCnt)) protoErr++;
                if (outSel) protoErr++;
                wgtCnt++;
            end
            if (op2Sel) begin
                op2Cnt++;
                op2Cyc = cyc;
                if (outSel || wgtRdEn) protoErr++;
            end
            if (ifmRdEn) begin
                if (ifmFirst < 0) ifmFirst = cyc;
                if (ifmRdAddr != CNT_W'(ifmCnt)) protoErr++;
                if (!outSel) protoErr++;
                ifmCnt++;
            end
            if (ofmWrEn) begin
                if (ofmFirst < 0) ofmFirst = cyc;
                if (ofmWrAddr != CNT_W'(ofmCnt)) protoErr++;
                ofmCnt++;
            end
            if (busy) busyCnt++;
            if (statBit != busy) protoErr++;
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
                if (!busy) protoErr++;
            end
            if (doneCnt > 0 && cyc >= doneCyc + 4) break;
            if (noise) begin
                if (cyc == 5)  begin start = 1'b1; numVec = CNT_W'(9); end
                if (cyc == 6)  start = 1'b0;
                if (cyc == 15) start = 1'b1;
                if (cyc == 16) start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic checkTile(input string n, input int eWgtCnt, input int eOp2Cyc,
                             input int eIfmCnt, input int eIfmFirst, input int eOfmFirst,
                             input int eDoneCyc);
        checkOutput({n, ".wgtCnt"},   wgtCnt,   eWgtCnt);
        checkOutput({n, ".wgtFirst"}, wgtFirst, (eWgtCnt > 0) ? 1 : -1);
        checkOutput({n, ".op2Cnt"},   op2Cnt,   (eOp2Cyc > 0) ? 1 : 0);
        checkOutput({n, ".op2Cyc"},   op2Cyc,   eOp2Cyc);
        checkOutput({n, ".ifmCnt"},   ifmCnt,   eIfmCnt);
        checkOutput({n, ".ifmFirst"}, ifmFirst, eIfmFirst);
        checkOutput({n, ".ofmCnt"},   ofmCnt,   eIfmCnt);
        checkOutput({n, ".ofmFirst"}, ofmFirst, eOfmFirst);
        checkOutput({n, ".doneCnt"},  doneCnt,  1);
        checkOutput({n, ".doneCyc"},  doneCyc,  eDoneCyc);
        checkOutput({n, ".busyCnt"},  busyCnt,  eDoneCyc);
        checkOutput({n, ".protoErr"}, protoErr, 0);
    endtask

    task automatic checkAllZero(input string n);
        checkOutput({n, ".flags"},
                    int'({busy, done, statBit, op2Sel, outSel, wgtRdEn, ifmRdEn, ofmWrEn}), 0);
        checkOutput({n, ".addrs"}, int'(wgtRdAddr) + int'(ifmRdAddr) + int'(ofmWrAddr), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; keepWeights = 1'b0; numVec = '0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        // keep_weights right after reset must still load weights
        applyStimulus(1'b1, 4, 1'b0);
        checkTile("t3", 8, 9, 4, 10, 19, 23);

        applyStimulus(1'b0, 4, 1'b0);
        checkTile("t1", 8, 9, 4, 10, 19, 23);

        applyStimulus(1'b1, 2, 1'b0);
        checkTile("t2", 0, -1, 2, 1, 10, 12);

        applyStimulus(1'b0, 0, 1'b0);
        checkTile("t4", 8, 9, 0, -1, -1, 10);

        applyStimulus(1'b1, 0, 1'b0);
        checkTile("t4b", 0, -1, 0, -1, -1, 1);

        // start pulses and a num_vec change while busy must be ignored
        applyStimulus(1'b0, 3, 1'b1);
        checkTile("t6", 8, 9, 3, 10, 19, 22);

        // reset in the middle of COMPUTE
        @(posedge clk); #1;
        start = 1'b1; keepWeights = 1'b0; numVec = CNT_W'(4);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("t5.computing", int'(ifmRdEn), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkAllZero("t5.afterReset");
        rst = 1'b0;
        applyStimulus(1'b1, 2, 1'b0);
        checkTile("t5b", 8, 9, 2, 10, 19, 21);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
